ucode_store: RTL and testbench

- Writable microprogram control store and microinstruction pipeline register for the MycaII microsequencer.
- Consumes the sequencer's 8-bit microaddress `PC`. Returns the fields the sequencer needs: `opc`, the condition bit `x`, and the branch target `DIRB`, plus 8 control lines.
- A byte-serial valid/ready loader fills the store at run time. The sequencer sees a forced continue/NOP microword until loading completes.

---
 rtl/ucode_store_if.sv | 29 ++
 rtl/ucode_store.sv | 174 +++++++++++++++++
 tb/tb_ucode_store.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ucode_store_if.sv
// rtl/ucode_store_if.sv - sequencer and byte-loader signal bundle for ucode_store
interface ucode_store_if;
  logic       ce;
  logic [7:0] PC;
  logic [1:0] cond;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic [2:0] opc;
  logic       x;
  logic [7:0] DIRB;
  logic [7:0] ctl;
  logic       run;
  logic       uerr;

  // Control store side
  modport slave (
    input  ce, PC, cond, ld_start, ld_valid, ld_data, ld_done,
    output ld_ready, opc, x, DIRB, ctl, run, uerr
  );

  // Sequencer / loader side
  modport master (
    output ce, PC, cond, ld_start, ld_valid, ld_data, ld_done,
    input  ld_ready, opc, x, DIRB, ctl, run, uerr
  );
endinterface

// File: rtl/ucode_store.sv
// rtl/ucode_store.sv - writable microprogram store with pipeline register; optional UCODE_PARITY_EN adds per-word parity
module ucode_store #(
  parameter logic [2:0] NOP_OPC = 3'b000,
  parameter int         DEPTH   = 256
) (
  input logic          ck,
  input logic          rst,
  ucode_store_if.slave bus
);

`ifdef UCODE_PARITY_EN
  // Fourth loader byte carries the parity bit in bit 0
  localparam int         MW       = 25;
  localparam int         HW       = 24;
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam int         MW       = 24;
  localparam int         HW       = 16;
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [1:0]      idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      opc_q, opc_d;
  logic [1:0]      csel_q, csel_d;
  logic [7:0]      dirb_q, dirb_d;
  logic [7:0]      ctl_q, ctl_d;
  logic [MW-1:0]   mem [DEPTH];
  logic [MW-1:0]   rword;
  logic [MW-1:0]   wdata;
  logic            accept;
  logic            we;
  logic            rd_bad;
  logic            x_w;
  logic            unused_bits;

  assign accept = (state_q == LOAD) && bus.ld_valid;
  // A restart on the same edge abandons the word being assembled
  assign we     = accept && (idx_q == LAST_IDX) && !bus.ld_start;
  assign rword  = mem[bus.PC];

`ifdef UCODE_PARITY_EN
  logic uerr_q, uerr_d;
  assign wdata       = {bus.ld_data[0], hold_q};
  assign rd_bad      = ^rword;
  assign bus.uerr    = uerr_q;
  assign unused_bits = ^{rword[2:0], bus.ld_data[7:1]};
`else
  assign wdata       = {bus.ld_data, hold_q};
  assign rd_bad      = 1'b0;
  assign bus.uerr    = 1'b0;
  assign unused_bits = ^rword[2:0];
`endif

  // Next-state: loader FSM, byte assembly and pipeline register
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    opc_d   = opc_q;
    csel_d  = csel_q;
    dirb_d  = dirb_q;
    ctl_d   = ctl_q;
`ifdef UCODE_PARITY_EN
    uerr_d  = uerr_q;
`endif
    if (accept) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = 2'd0;
        addr_d = addr_q + 8'd1;
      end else begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0: hold_d[7:0]   = bus.ld_data;
          2'd1: hold_d[15:8]  = bus.ld_data;
`ifdef UCODE_PARITY_EN
          2'd2: hold_d[23:16] = bus.ld_data;
`endif
          default: ;
        endcase
      end
    end
    if (bus.ce) begin
      if ((state_q == RUN) && !rd_bad) begin
        opc_d  = rword[23:21];
        csel_d = rword[20:19];
        dirb_d = rword[18:11];
        ctl_d  = rword[10:3];
      end else begin
        opc_d  = NOP_OPC;
        csel_d = 2'd0;
        dirb_d = 8'd0;
        ctl_d  = 8'd0;
      end
`ifdef UCODE_PARITY_EN
      if ((state_q == RUN) && rd_bad) uerr_d = 1'b1;
`endif
    end
    if (bus.ld_start) begin
      state_d = LOAD;
      addr_d  = 8'd0;
      idx_d   = 2'd0;
      opc_d   = NOP_OPC;
      csel_d  = 2'd0;
      dirb_d  = 8'd0;
      ctl_d   = 8'd0;
`ifdef UCODE_PARITY_EN
      uerr_d  = 1'b0;
`endif
    end else if ((state_q == LOAD) && bus.ld_done) begin
      state_d = RUN;
      idx_d   = 2'd0;
    end
  end

  // State register with asynchronous reset; store contents are not reset
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      opc_q   <= NOP_OPC;
      csel_q  <= 2'd0;
      dirb_q  <= 8'd0;
      ctl_q   <= 8'd0;
`ifdef UCODE_PARITY_EN
      uerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      opc_q   <= opc_d;
      csel_q  <= csel_d;
      dirb_q  <= dirb_d;
      ctl_q   <= ctl_d;
`ifdef UCODE_PARITY_EN
      uerr_q  <= uerr_d;
`endif
    end
  end

  // Word write on the edge that accepts the last byte
  always_ff @(posedge ck) begin
    if (we) mem[addr_q] <= wdata;
  end

  // Condition select follows the live conditions combinationally
  always_comb begin
    x_w = 1'b0;
    case (csel_q)
      2'd0: x_w = 1'b0;
      2'd1: x_w = 1'b1;
      2'd2: x_w = bus.cond[0];
      2'd3: x_w = bus.cond[1];
      default: x_w = 1'b0;
    endcase
  end

  assign bus.x        = x_w;
  assign bus.opc      = opc_q;
  assign bus.DIRB     = dirb_q;
  assign bus.ctl      = ctl_q;
  assign bus.run      = (state_q == RUN);
  assign bus.ld_ready = (state_q == LOAD);

endmodule

// File: tb/tb_ucode_store.sv
// tb/tb_ucode_store.sv - scoreboard bench for ucode_store
module tb_ucode_store;
  localparam logic [2:0] NOP = 3'b100;

  typedef struct {
    string      name;
    logic [2:0] opc;
    logic [7:0] dirb;
    logic [7:0] ctl;
    logic       x;
    logic       run;
    logic       ldr;
    logic       uerr;
  } exp_t;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic ce_d = 1'b0;
  logic probe = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  ucode_store_if bus ();

  ucode_store #(.NOP_OPC(NOP), .DEPTH(256)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  always @(posedge ck) ce_d <= bus.ce;

  function automatic logic [23:0] mkword(input logic [2:0] o, input logic [1:0] c,
                                         input logic [7:0] d, input logic [7:0] t);
    return {o, c, d, t, 3'b000};
  endfunction

  function automatic exp_t ex(input string n, input logic [2:0] o, input logic [7:0] d,
                              input logic [7:0] c, input logic xx, input logic r,
                              input logic l, input logic u);
    exp_t e;
    e.name = n; e.opc = o; e.dirb = d; e.ctl = c; e.x = xx; e.run = r; e.ldr = l; e.uerr = u;
    return e;
  endfunction

  // Monitor: pops one expectation whenever a fetch result or a probe is presented
  always @(negedge ck) begin
    exp_t e;
    logic [22:0] act;
    logic [22:0] want;
    if (ce_d || probe) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got opc=%0d DIRB=%h, required no output", bus.opc, bus.DIRB);
      end else begin
        e = sb.pop_front();
        act  = {bus.opc, bus.DIRB, bus.ctl, bus.x, bus.run, bus.ld_ready, bus.uerr};
        want = {e.opc, e.dirb, e.ctl, e.x, e.run, e.ldr, e.uerr};
        if (act === want) n_pass++;
        else $display("FAIL %s: got opc=%0d DIRB=%h ctl=%h x=%b run=%b ld_ready=%b uerr=%b, required opc=%0d DIRB=%h ctl=%h x=%b run=%b ld_ready=%b uerr=%b",
                      e.name, bus.opc, bus.DIRB, bus.ctl, bus.x, bus.run, bus.ld_ready, bus.uerr,
                      e.opc, e.dirb, e.ctl, e.x, e.run, e.ldr, e.uerr);
      end
    end
  end

  task automatic probe_chk(input exp_t e);
    sb.push_back(e);
    probe = 1'b1;
    @(negedge ck);
    #1 probe = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] pc, input exp_t e);
    bus.PC = pc;
    bus.ce = 1'b1;
    sb.push_back(e);
    @(posedge ck);
    #1 bus.ce = 1'b0;
    @(negedge ck);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    @(posedge ck);
    #1 bus.ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
`ifdef UCODE_PARITY_EN
    send_byte({7'b0, ^w});
`endif
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    @(posedge ck);
    #1 bus.ld_start = 1'b0;
  endtask

  task automatic done_load();
    bus.ld_done = 1'b1;
    @(posedge ck);
    #1 bus.ld_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  initial begin
    logic [23:0] wc;
    logic [7:0]  b;
    bus.ce = 1'b0; bus.PC = 8'd0; bus.cond = 2'b00;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 8'd0; bus.ld_done = 1'b0;
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;
    probe_chk(ex("reset_state", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

    start_load();
    probe_chk(ex("load_entered", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    send_byte(8'h00); send_byte(8'h48); send_byte(8'hE5);
`ifdef UCODE_PARITY_EN
    send_byte(8'h01);
`endif
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
`ifdef UCODE_PARITY_EN
    send_byte(8'h01);
`endif
    send_word(mkword(3'd2, 2'd2, 8'h5A, 8'hC3));
    send_word(mkword(3'd5, 2'd3, 8'h81, 8'h3C));
    send_word(mkword(3'd0, 2'd1, 8'h11, 8'h22));
    done_load();
    probe_chk(ex("run_entered", NOP, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));

    fetch(8'd0, ex("fetch_w0", 3'd7, 8'hA9, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    fetch(8'd1, ex("fetch_w1", 3'd1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    fetch(8'd2, ex("fetch_csel2", 3'd2, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0));
    bus.cond = 2'b01;
    probe_chk(ex("csel2_cond0_hi", 3'd2, 8'h5A, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0));
    bus.cond = 2'b00;
    probe_chk(ex("csel2_cond0_lo", 3'd2, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0));
    fetch(8'd3, ex("fetch_csel3", 3'd5, 8'h81, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0));
    bus.cond = 2'b10;
    probe_chk(ex("csel3_cond1_hi", 3'd5, 8'h81, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0));
    bus.cond = 2'b00;
    fetch(8'd4, ex("fetch_csel1", 3'd0, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0));

    rst = 1'b1;
    probe_chk(ex("reset_mid_run", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge ck);
    #1 rst = 1'b0;
    fetch(8'd2, ex("ce_in_idle", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    start_load();
    done_load();
    fetch(8'd2, ex("mem_kept_after_reset", 3'd2, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0));

    start_load();
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      send_word(mkword(b[2:0], 2'd0, b, ~b));
    end
    send_word(mkword(3'd6, 2'd1, 8'hEE, 8'h77));
    done_load();
    fetch(8'd0, ex("wrap_overwrite_0", 3'd6, 8'hEE, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0));
    fetch(8'd255, ex("wrap_last_255", 3'd7, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    fetch(8'd1, ex("wrap_word_1", 3'd1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0));

    start_load();
    send_word(mkword(3'd3, 2'd0, 8'h33, 8'h44));
    send_byte(8'hAA);
    send_byte(8'hBB);
    done_load();
    fetch(8'd1, ex("abort_addr1_kept", 3'd1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0));
    fetch(8'd0, ex("abort_addr0_new", 3'd3, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0));

    bus.ld_start = 1'b1;
    bus.ld_done  = 1'b1;
    @(posedge ck);
    #1 bus.ld_start = 1'b0; bus.ld_done = 1'b0;
    probe_chk(ex("start_beats_done", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    wc = mkword(3'd5, 2'd2, 8'hC5, 8'h5C);
    send_byte(wc[7:0]);
    send_byte(wc[15:8]);
    repeat (4) @(posedge ck);
    probe_chk(ex("stall_ready_held", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    send_byte(wc[23:16]);
`ifdef UCODE_PARITY_EN
    send_byte({7'b0, ^wc});
`endif
    done_load();
    bus.cond = 2'b01;
    fetch(8'd0, ex("stall_word_ok", 3'd5, 8'hC5, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b0));
    fetch(8'd1, ex("stall_no_stray_write", 3'd1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0));

`ifdef UCODE_PARITY_EN
    wc = mkword(3'd2, 2'd1, 8'h12, 8'h34);
    start_load();
    send_byte(wc[7:0]); send_byte(wc[15:8]); send_byte(wc[23:16]);
    send_byte({7'b0, ~(^wc)});
    done_load();
    fetch(8'd0, ex("parity_bad_nop", NOP, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
    fetch(8'd1, ex("parity_uerr_sticky", 3'd1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1));
    start_load();
    probe_chk(ex("parity_uerr_cleared", NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
`endif

    repeat (3) @(posedge ck);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
